// File: rtl/axis_dw_pkg.sv
// Shared AXI-Stream width-converter definitions: FSM state encoding and lane-index sizing.
// Imported by both the upsizer and the downsizer so lane ordering stays consistent.
package axis_dw_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } dw_state_t;

    // Width of a lane index; never narrower than one bit.
    function automatic int lane_w(input int num_reg);
        return (num_reg > 2) ? $clog2(num_reg) : 1;
    endfunction

endpackage

// File: rtl/my_axis_dwidth_downsize.sv
// AXI-Stream downsizer: one WIDTH*NUM_REG-bit beat in, NUM_REG WIDTH-bit beats out, MSB lane first.
// Define AXIS_DOWNSIZE_TKEEP_EN to add s_axis_tkeep and skip trailing unkept lanes.
module my_axis_dwidth_downsize
    import axis_dw_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NUM_REG = 2
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic [WIDTH*NUM_REG-1:0] s_axis_tdata,
    input  logic                     s_axis_tlast,
`ifdef AXIS_DOWNSIZE_TKEEP_EN
    input  logic [NUM_REG-1:0]       s_axis_tkeep,
`endif
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic [WIDTH-1:0]         m_axis_tdata,
    output logic                     m_axis_tlast
);

    localparam int DW = WIDTH * NUM_REG;
    localparam int LW = lane_w(NUM_REG);
    localparam logic [LW-1:0] TOP_LANE = LW'(NUM_REG - 1);

    dw_state_t     state;
    logic [LW-1:0] lane;
    logic [LW-1:0] last_lane;
    logic [LW-1:0] next_lane;
    logic [LW-1:0] in_last_lane;
    logic          in_empty;
    logic [DW-1:0] hold;
    logic          saved_tlast;
    logic          s_fire;
    logic          m_fire;

    // Lowest lane to emit for the incoming beat; kept lanes are contiguous from the MSB.
    always_comb begin
`ifdef AXIS_DOWNSIZE_TKEEP_EN
        in_last_lane = TOP_LANE;
        in_empty     = ~|s_axis_tkeep;
        for (int k = NUM_REG - 1; k >= 0; k--) begin
            if (s_axis_tkeep[k]) in_last_lane = LW'(k);
        end
`else
        in_last_lane = '0;
        in_empty     = 1'b0;
`endif
    end

    assign next_lane     = lane - 1'b1;
    assign s_axis_tready = (state == IDLE) |
                           ((state == SEND) & (lane == last_lane) & m_axis_tready);
    assign s_fire        = s_axis_tvalid & s_axis_tready;
    assign m_fire        = m_axis_tvalid & m_axis_tready;

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state         <= IDLE;
            lane          <= '0;
            last_lane     <= '0;
            // NOTE: the holding register is reset too, so no stale wide word survives a reset.
            hold          <= '0;
            saved_tlast   <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
        end else if (s_fire) begin
            hold        <= s_axis_tdata;
            saved_tlast <= s_axis_tlast;
            lane        <= TOP_LANE;
            last_lane   <= in_last_lane;
            if (in_empty) begin
                state         <= IDLE;
                m_axis_tvalid <= 1'b0;
                m_axis_tlast  <= 1'b0;
            end else begin
                state         <= SEND;
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= s_axis_tdata[DW-1 -: WIDTH];
                m_axis_tlast  <= s_axis_tlast && (in_last_lane == TOP_LANE);
            end
        end else if (m_fire) begin
            if (lane != last_lane) begin
                lane         <= next_lane;
                m_axis_tdata <= hold[int'(next_lane) * WIDTH +: WIDTH];
                m_axis_tlast <= saved_tlast && (next_lane == last_lane);
            end else begin
                state         <= IDLE;
                m_axis_tvalid <= 1'b0;
                m_axis_tlast  <= 1'b0;
            end
        end
    end

`ifndef SYNTHESIS
    a_stall_stable: assert property (@(posedge aclk) disable iff (areset)
        m_axis_tvalid && !m_axis_tready |=> m_axis_tvalid && $stable(m_axis_tdata) && $stable(m_axis_tlast));

    a_valid_in_send: assert property (@(posedge aclk) disable iff (areset)
        (state == SEND) == m_axis_tvalid);

    a_lane_no_wrap: assert property (@(posedge aclk) disable iff (areset)
        (state == SEND) |-> (lane >= last_lane));

`ifdef AXIS_DOWNSIZE_TKEEP_EN
    a_empty_keep_no_last: assert property (@(posedge aclk) disable iff (areset)
        s_fire |-> !((~|s_axis_tkeep) && s_axis_tlast));
`endif
`endif

endmodule
